regfile_sequencer: RTL and testbench

Command-driven initiator for the 32×32 register file: accepts one register operation at a time over a valid/ready command port, drives the register file's two read ports and one write port over one or two cycles, and returns a result over a valid/ready response port. It sits between a test or control master and the register file. It owns every register-file access so that multi-step operations (copy, swap) are atomic with respect to other masters.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile.sv | 31 +++
 rtl/regfile_sequencer.sv | 155 +++++++++++++++
 tb/tb_regfile_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its command sequencer:
// operation codes, sequencer state encoding, default widths and the hardwired-zero index.
package regfile_pkg;

    localparam int DataWidth = 32;
    localparam int AddrWidth = 5;
    localparam int ZERO_REG  = 0;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_COPY  = 2'd2,
        OP_SWAP  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SWAP2 = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/regfile.sv
// 2-read/1-write register file with asynchronous read; register 0 always reads as zero.
// Contents are deliberately not reset so that an aborted sequencer operation leaves its partial effect visible.
module regfile #(
    parameter int DataWidth = regfile_pkg::DataWidth,
    parameter int AddrWidth = regfile_pkg::AddrWidth
) (
    input  logic                 Clk,
    input  logic [AddrWidth-1:0] ReadRegister1,
    input  logic [AddrWidth-1:0] ReadRegister2,
    output logic [DataWidth-1:0] ReadData1,
    output logic [DataWidth-1:0] ReadData2,
    input  logic [AddrWidth-1:0] WriteRegister,
    input  logic [DataWidth-1:0] WriteData,
    input  logic                 RegWrite
);
    import regfile_pkg::*;

    localparam int Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] regs_q [Depth];

    always_ff @(posedge Clk) begin
        if (RegWrite && (WriteRegister != AddrWidth'(ZERO_REG))) begin
            regs_q[WriteRegister] <= WriteData;
        end
    end

    assign ReadData1 = (ReadRegister1 == AddrWidth'(ZERO_REG)) ? '0 : regs_q[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == AddrWidth'(ZERO_REG)) ? '0 : regs_q[ReadRegister2];

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven initiator owning all register-file accesses, so multi-step ops (COPY, SWAP)
// stay atomic; one command in flight, result returned over a valid/ready response port.
module regfile_sequencer #(
    parameter int DataWidth = regfile_pkg::DataWidth,
    parameter int AddrWidth = regfile_pkg::AddrWidth
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic                 CmdValid,
    output logic                 CmdReady,
    input  logic [1:0]           CmdOp,
    input  logic [AddrWidth-1:0] CmdRs,
    input  logic [AddrWidth-1:0] CmdRt,
    input  logic [AddrWidth-1:0] CmdRd,
    input  logic [DataWidth-1:0] CmdImm,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [DataWidth-1:0] RspData,
    output logic                 RspErr,
    output logic [AddrWidth-1:0] ReadRegister1,
    output logic [AddrWidth-1:0] ReadRegister2,
    input  logic [DataWidth-1:0] ReadData1,
    input  logic [DataWidth-1:0] ReadData2,
    output logic [AddrWidth-1:0] WriteRegister,
    output logic [DataWidth-1:0] WriteData,
    output logic                 RegWrite
);
    import regfile_pkg::*;

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [AddrWidth-1:0] rs_q, rs_d;
    logic [AddrWidth-1:0] rt_q, rt_d;
    logic [AddrWidth-1:0] rd_q, rd_d;
    logic [DataWidth-1:0] imm_q, imm_d;
    logic [DataWidth-1:0] temp_q, temp_d;
    logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q    <= S_IDLE;
            op_q       <= OP_WRITE;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            temp_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            temp_q     <= temp_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        temp_d     = temp_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        CmdReady   = 1'b0;
        RspValid   = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;

        unique case (state_q)
            S_IDLE: begin
                CmdReady = 1'b1;
                if (CmdValid) begin
                    op_d    = op_e'(CmdOp);
                    rs_d    = CmdRs;
                    rt_d    = CmdRt;
                    rd_d    = CmdRd;
                    imm_d   = CmdImm;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (op_q == OP_SWAP) ? S_SWAP2 : S_RESP;
                unique case (op_q)
                    OP_WRITE: begin
                        wr_en      = 1'b1;
                        wr_addr    = rd_q;
                        wr_data    = imm_q;
                        rsp_data_d = imm_q;
                        rsp_err_d  = (rd_q == AddrWidth'(ZERO_REG));
                    end
                    OP_READ: begin
                        rsp_data_d = ReadData1;
                        rsp_err_d  = 1'b0;
                    end
                    OP_COPY: begin
                        wr_en      = 1'b1;
                        wr_addr    = rd_q;
                        wr_data    = ReadData1;
                        rsp_data_d = ReadData1;
                        rsp_err_d  = (rd_q == AddrWidth'(ZERO_REG));
                    end
                    OP_SWAP: begin
                        // Rt is read in this same cycle, before Rs is overwritten at the edge.
                        wr_en      = 1'b1;
                        wr_addr    = rs_q;
                        wr_data    = ReadData2;
                        temp_d     = ReadData1;
                        rsp_data_d = ReadData1;
                        rsp_err_d  = (rs_q == AddrWidth'(ZERO_REG));
                    end
                    default: ;
                endcase
            end
            S_SWAP2: begin
                wr_en     = 1'b1;
                wr_addr   = rt_q;
                wr_data   = temp_q;
                rsp_err_d = rsp_err_q | (rt_q == AddrWidth'(ZERO_REG));
                state_d   = S_RESP;
            end
            S_RESP: begin
                RspValid = 1'b1;
                if (RspReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gated by ResetN so nothing commits on the edge that aborts an operation.
    assign RegWrite      = wr_en & ResetN & (wr_addr != AddrWidth'(ZERO_REG));
    assign WriteRegister = wr_addr;
    assign WriteData     = wr_data;
    assign ReadRegister1 = rs_q;
    assign ReadRegister2 = rt_q;
    assign RspData       = rsp_data_q;
    assign RspErr        = rsp_err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed plus randomized test of regfile_sequencer driving a regfile, checked against
// an array model of the register contents updated by each operation's semantics.
module tb_regfile_sequencer;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          ResetN, CmdValid, CmdReady, RspValid, RspReady, RspErr, RegWrite;
    logic [1:0]    CmdOp;
    logic [AW-1:0] CmdRs, CmdRt, CmdRd;
    logic [DW-1:0] CmdImm, RspData;
    logic [AW-1:0] ReadRegister1, ReadRegister2, WriteRegister;
    logic [DW-1:0] ReadData1, ReadData2, WriteData;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] model [32];

    always #5 Clk = ~Clk;

    regfile_sequencer #(.DataWidth(DW), .AddrWidth(AW)) u_dut (
        .Clk(Clk), .ResetN(ResetN),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
        .CmdRs(CmdRs), .CmdRt(CmdRt), .CmdRd(CmdRd), .CmdImm(CmdImm),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite)
    );

    regfile #(.DataWidth(DW), .AddrWidth(AW)) u_rf (
        .Clk(Clk),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full command/response transaction with cycle-exact checks; model updated afterwards.
    task automatic run_op(input logic [1:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] rd, input logic [DW-1:0] imm, input int hold);
        logic [DW-1:0] a, b, exp_data, exp_wd;
        logic [AW-1:0] exp_wa;
        logic          exp_err, exp_we;
        a = model[rs];
        b = model[rt];
        case (op)
            2'd0:    begin exp_data = imm; exp_err = (rd == 0); exp_wa = rd; exp_wd = imm; end
            2'd1:    begin exp_data = a;   exp_err = 1'b0;      exp_wa = '0; exp_wd = '0;  end
            2'd2:    begin exp_data = a;   exp_err = (rd == 0); exp_wa = rd; exp_wd = a;   end
            default: begin exp_data = a;   exp_err = (rs == 0) || (rt == 0); exp_wa = rs; exp_wd = b; end
        endcase
        exp_we = (op != 2'd1) && (exp_wa != 0);

        @(negedge Clk);
        chk("idle_cmd_ready", DW'(CmdReady), 1);
        CmdValid = 1'b1; CmdOp = op; CmdRs = rs; CmdRt = rt; CmdRd = rd; CmdImm = imm;
        @(posedge Clk);
        #1 CmdValid = 1'b0;

        @(negedge Clk);
        chk("exec_rsp_valid", DW'(RspValid), 0);
        chk("exec_cmd_ready", DW'(CmdReady), 0);
        chk("exec_raddr1", DW'(ReadRegister1), DW'(rs));
        chk("exec_regwrite", DW'(RegWrite), DW'(exp_we));
        if (exp_we) begin
            chk("exec_waddr", DW'(WriteRegister), DW'(exp_wa));
            chk("exec_wdata", WriteData, exp_wd);
        end
        if (op == 2'd3) begin
            @(negedge Clk);
            chk("swap2_rsp_valid", DW'(RspValid), 0);
            chk("swap2_regwrite", DW'(RegWrite), DW'(rt != 0));
            if (rt != 0) begin
                chk("swap2_waddr", DW'(WriteRegister), DW'(rt));
                chk("swap2_wdata", WriteData, a);
            end
        end

        @(negedge Clk);
        chk("rsp_valid", DW'(RspValid), 1);
        chk("rsp_data", RspData, exp_data);
        chk("rsp_err", DW'(RspErr), DW'(exp_err));
        chk("rsp_regwrite", DW'(RegWrite), 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge Clk);
            chk("hold_valid", DW'(RspValid), 1);
            chk("hold_data", RspData, exp_data);
            chk("hold_err", DW'(RspErr), DW'(exp_err));
            chk("hold_cmd_ready", DW'(CmdReady), 0);
        end
        RspReady = 1'b1;
        @(posedge Clk);
        #1 RspReady = 1'b0;
        @(negedge Clk);
        chk("post_rsp_valid", DW'(RspValid), 0);
        chk("post_cmd_ready", DW'(CmdReady), 1);

        case (op)
            2'd0: if (rd != 0) model[rd] = imm;
            2'd2: if (rd != 0) model[rd] = a;
            2'd3: begin
                if (rs != 0) model[rs] = b;
                if (rt != 0) model[rt] = a;
            end
            default: ;
        endcase
        $display("op=%0d rs=%0d rt=%0d rd=%0d imm=%h hold=%0d -> data=%h err=%0b",
                 op, rs, rt, rd, imm, hold, RspData, RspErr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        ResetN = 1'b0; CmdValid = 1'b0; RspReady = 1'b0;
        CmdOp = '0; CmdRs = '0; CmdRt = '0; CmdRd = '0; CmdImm = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_cmd_ready", DW'(CmdReady), 1);
        chk("rst_rsp_valid", DW'(RspValid), 0);
        chk("rst_rsp_data", RspData, 0);
        chk("rst_rsp_err", DW'(RspErr), 0);
        chk("rst_regwrite", DW'(RegWrite), 0);
        chk("rst_raddr1", DW'(ReadRegister1), 0);
        chk("rst_raddr2", DW'(ReadRegister2), 0);
        chk("rst_waddr", DW'(WriteRegister), 0);
        chk("rst_wdata", WriteData, 0);
        ResetN = 1'b1;

        run_op(2'd0, 5'd0, 5'd0, 5'd15, 32'h15, 0);
        run_op(2'd0, 5'd0, 5'd0, 5'd3, 32'hDEADBEEF, 0);
        run_op(2'd1, 5'd3, 5'd0, 5'd0, 32'h0, 0);
        run_op(2'd0, 5'd0, 5'd0, 5'd4, 32'hA, 0);
        run_op(2'd0, 5'd0, 5'd0, 5'd5, 32'hB, 0);
        run_op(2'd3, 5'd4, 5'd5, 5'd0, 32'h0, 0);
        run_op(2'd1, 5'd4, 5'd0, 5'd0, 32'h0, 0);
        run_op(2'd1, 5'd5, 5'd0, 5'd0, 32'h0, 0);
        chk("swap_r4", model[4], 32'hB);
        run_op(2'd0, 5'd0, 5'd0, 5'd0, 32'h1234, 0);
        run_op(2'd1, 5'd0, 5'd0, 5'd0, 32'h0, 0);
        run_op(2'd2, 5'd3, 5'd0, 5'd7, 32'h0, 5);
        run_op(2'd1, 5'd7, 5'd0, 5'd0, 32'h0, 0);

        // Abort a SWAP during its second write.
        run_op(2'd0, 5'd0, 5'd0, 5'd4, 32'h44, 0);
        run_op(2'd0, 5'd0, 5'd0, 5'd5, 32'h55, 0);
        @(negedge Clk);
        CmdValid = 1'b1; CmdOp = 2'd3; CmdRs = 5'd4; CmdRt = 5'd5; CmdRd = 5'd0; CmdImm = '0;
        @(posedge Clk);
        #1 CmdValid = 1'b0;
        @(negedge Clk);
        chk("abort_exec_regwrite", DW'(RegWrite), 1);
        @(negedge Clk);
        ResetN = 1'b0;
        #1 chk("abort_swap2_regwrite", DW'(RegWrite), 0);
        @(posedge Clk);
        #1 ResetN = 1'b1;
        @(negedge Clk);
        chk("abort_rsp_valid", DW'(RspValid), 0);
        chk("abort_cmd_ready", DW'(CmdReady), 1);
        chk("abort_rsp_data", RspData, 0);
        chk("abort_rsp_err", DW'(RspErr), 0);
        model[4] = 32'h55;
        run_op(2'd1, 5'd4, 5'd0, 5'd0, 32'h0, 0);
        run_op(2'd1, 5'd5, 5'd0, 5'd0, 32'h0, 0);

        for (int r = 1; r < 32; r++) run_op(2'd0, 5'd0, 5'd0, AW'(r), $urandom, 0);
        for (int t = 0; t < 60; t++) begin
            run_op(2'($urandom_range(0, 3)), AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                   AW'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 2)));
        end
        for (int r = 0; r < 32; r++) run_op(2'd1, AW'(r), 5'd0, 5'd0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
